// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus for instr_encoder_loader.
// The master side produces requests and owns wr_ready; the slave is the encoder.
interface instr_encoder_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        req_last;
  logic        wr_en;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target, req_last, wr_ready,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target, req_last, wr_ready,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs mnemonic requests into MIPS instruction words and streams them to instruction memory.
// Define FP_LDST_EN to add LWC1/SWC1 encodings (ops 13/14); otherwise they are illegal.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned CNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_complete;
  logic             w_accept;
  logic             w_legal;
  logic             w_room;
  logic             w_full;
  logic [31:0]      w_enc;
  logic [CNT_W:0]   w_fill;

  // Words written plus the one held in the output register.
  assign w_fill     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_wr_en};
  assign w_room     = w_fill < (CNT_W+1)'(DEPTH);
  assign w_full     = w_fill == (CNT_W+1)'(DEPTH);
  assign w_complete = r_wr_en & bus.wr_ready;

  assign bus.req_ready = (r_state == S_RUN) & (~r_wr_en | bus.wr_ready) & w_room;
  assign w_accept      = bus.req_valid & bus.req_ready;

  always_comb begin
    w_legal = 1'b1;
    w_enc   = '0;
    case (bus.req_op)
      4'd0:  w_enc = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h20};
      4'd1:  w_enc = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h22};
      4'd2:  w_enc = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h24};
      4'd3:  w_enc = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h25};
      4'd4:  w_enc = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h2A};
      4'd5:  w_enc = {6'h00, bus.req_rs, 15'd0, 6'h08};
      4'd6:  w_enc = {6'h08, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd7:  w_enc = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd8:  w_enc = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd9:  w_enc = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd10: w_enc = {6'h05, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd11: w_enc = {6'h02, bus.req_target};
      4'd12: w_enc = {6'h03, bus.req_target};
`ifdef FP_LDST_EN
      4'd13: w_enc = {6'h31, bus.req_rs, bus.req_rt, bus.req_imm};
      4'd14: w_enc = {6'h39, bus.req_rs, bus.req_rt, bus.req_imm};
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= BASE_ADDR;
      r_wr_data <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else if (start) begin
      r_state   <= S_RUN;
      r_wr_en   <= 1'b0;
      r_wr_addr <= BASE_ADDR;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_complete) begin
        r_wr_addr <= r_wr_addr + 32'd4;
        r_cnt     <= r_cnt + 1'b1;
      end
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            // Acceptance implies any held word completes this cycle, so an
            // illegal request leaves nothing pending and may finish directly.
            r_wr_en <= w_legal;
            if (w_legal) r_wr_data <= w_enc;
            else         r_err     <= 1'b1;
            if (bus.req_last) r_state <= w_legal ? S_DRAIN : S_DONE;
          end else begin
            if (w_complete) r_wr_en <= 1'b0;
            if (bus.req_valid & w_full & ~w_complete) r_err <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_complete) begin
            r_wr_en <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign busy        = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;
  assign word_cnt    = r_cnt;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a cycle-level reference model.
// Honours FP_LDST_EN in the same way as the design.
module tb_instr_encoder_loader;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    bit          last;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;
  logic [CNT_W-1:0] word_cnt;

  instr_encoder_loader_if bus ();

  instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 accepting, 2 draining, 3 done pulse.
  int          m_phase = 0;
  int unsigned m_cnt = 0, m_issued = 0;
  bit          m_err = 0;
  logic [31:0] m_qa[$], m_qd[$];
  logic [31:0] log_a[$], log_d[$];
  req_t        prog[$];

  function automatic bit ref_encode(input req_t r, output logic [31:0] w);
    int unsigned opc, fn;
    bit rtype, itype, jtype;
    w = 0; rtype = 0; itype = 0; jtype = 0; opc = 0; fn = 0;
    case (r.op)
      0: begin rtype = 1; fn = 32; end
      1: begin rtype = 1; fn = 34; end
      2: begin rtype = 1; fn = 36; end
      3: begin rtype = 1; fn = 37; end
      4: begin rtype = 1; fn = 42; end
      5: begin w = r.rs * (1 << 21) + 8; return 1; end
      6: begin itype = 1; opc = 8;  end
      7: begin itype = 1; opc = 35; end
      8: begin itype = 1; opc = 43; end
      9: begin itype = 1; opc = 4;  end
      10: begin itype = 1; opc = 5; end
      11: begin jtype = 1; opc = 2; end
      12: begin jtype = 1; opc = 3; end
`ifdef FP_LDST_EN
      13: begin itype = 1; opc = 49; end
      14: begin itype = 1; opc = 57; end
`endif
      default: return 0;
    endcase
    if (rtype) w = r.rs * (1 << 21) + r.rt * (1 << 16) + r.rd * (1 << 11) + fn;
    if (itype) w = opc * (1 << 26) + r.rs * (1 << 21) + r.rt * (1 << 16) + r.imm;
    if (jtype) w = opc * (1 << 26) + r.tgt;
    return 1;
  endfunction

  // Inputs are already driven for this cycle; compare, then advance the model across the edge.
  task automatic tick(input req_t r, output bit acc);
    bit exp_ready, comp, legal;
    int unsigned pend;
    logic [31:0] w;
    #1;
    pend = m_qd.size();
    exp_ready = (m_phase == 1) && (pend == 0 || bus.wr_ready) && (m_cnt + pend < DEPTH);
    check("req_ready", bus.req_ready, exp_ready);
    check("wr_en", bus.wr_en, pend != 0);
    if (pend != 0) begin
      check("wr_addr", bus.wr_addr, m_qa[0]);
      check("wr_data", bus.wr_data, m_qd[0]);
    end
    check("busy", busy, m_phase == 1 || m_phase == 2);
    check("done", done, m_phase == 3);
    check("err", err, m_err);
    check("word_cnt", word_cnt, m_cnt);
    comp = (pend != 0) && bus.wr_ready;
    acc  = bus.req_valid && exp_ready && !start;
    if (start) begin
      m_phase = 1; m_cnt = 0; m_issued = 0; m_err = 0;
      m_qa.delete(); m_qd.delete();
    end else begin
      if (comp) begin
        log_a.push_back(bus.wr_addr);
        log_d.push_back(bus.wr_data);
        void'(m_qa.pop_front()); void'(m_qd.pop_front());
        m_cnt++;
      end
      case (m_phase)
        1: begin
          if (acc) begin
            legal = ref_encode(r, w);
            if (legal) begin
              m_qa.push_back(BASE + 4 * m_issued);
              m_qd.push_back(w);
              m_issued++;
            end else m_err = 1;
            if (r.last) m_phase = legal ? 2 : 3;
          end else if (bus.req_valid && (m_cnt + pend - (comp ? 1 : 0) + (comp ? 1 : 0) == DEPTH) && !comp)
            m_err = 1;
        end
        2: if (comp) m_phase = 3;
        3: m_phase = 0;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic drive_req(input req_t r, input bit v);
    bus.req_valid  = v;
    bus.req_op     = r.op;
    bus.req_rs     = r.rs;
    bus.req_rt     = r.rt;
    bus.req_rd     = r.rd;
    bus.req_imm    = r.imm;
    bus.req_target = r.tgt;
    bus.req_last   = r.last;
  endtask

  // mode 0: wr_ready always 1; mode 1: random; mode 2: first 3 write cycles stalled.
  task automatic run_program(input int mode, input int budget);
    req_t idle_r;
    int unsigned idx, stall;
    bit acc, v;
    idle_r = '{op: 0, rs: 0, rt: 0, rd: 0, imm: 0, tgt: 0, last: 0};
    log_a.delete(); log_d.delete();
    idx = 0; stall = 0;
    start = 1'b1;
    drive_req(idle_r, 1'b0);
    bus.wr_ready = 1'b1;
    tick(idle_r, acc);
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      v = (idx < prog.size());
      if (mode == 1 && $urandom_range(0, 4) == 0) v = 0;
      drive_req(v ? prog[idx] : idle_r, v);
      if (mode == 1) bus.wr_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && bus.wr_en && stall < 3) begin bus.wr_ready = 1'b0; stall++; end
      else bus.wr_ready = 1'b1;
      tick(v ? prog[idx] : idle_r, acc);
      if (acc) idx++;
      if (m_phase == 0) break;
    end
    drive_req(idle_r, 1'b0);
  endtask

  function automatic req_t mk(input int op, input int rs, input int rt, input int rd,
                              input int imm, input int tgt, input bit last);
    mk = '{op: 4'(op), rs: 5'(rs), rt: 5'(rt), rd: 5'(rd), imm: 16'(imm), tgt: 26'(tgt), last: last};
  endfunction

  initial begin
    req_t r;
    drive_req(mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
    bus.wr_ready = 1'b1;
    #2;
    check("rst_ready", bus.req_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", bus.wr_addr, BASE);
    check("rst_data", bus.wr_data, 0);
    check("rst_cnt", word_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    prog = '{mk(6, 0, 8, 0, 5, 0, 1)};
    run_program(0, 20);
    check("t1_n", log_d.size(), 1);
    if (log_d.size() == 1) begin
      check("t1_addr", log_a[0], 32'h0);
      check("t1_data", log_d[0], 32'h20080005);
    end
    check("t1_cnt", word_cnt, 1);

    prog = '{mk(0, 8, 9, 10, 0, 0, 0), mk(7, 29, 9, 0, 4, 0, 0),
             mk(5, 31, 0, 0, 0, 0, 0), mk(11, 0, 0, 0, 0, 26'h100000, 1)};
    run_program(0, 30);
    check("t2_n", log_d.size(), 4);
    if (log_d.size() == 4) begin
      check("t2_a3", log_a[3], 32'hC);
      check("t2_d0", log_d[0], 32'h01095020);
      check("t2_d1", log_d[1], 32'h8FA90004);
      check("t2_d2", log_d[2], 32'h03E00008);
      check("t2_d3", log_d[3], 32'h08100000);
    end

    prog = '{mk(9, 8, 9, 0, 16'hFFFF, 0, 0), mk(0, 1, 2, 3, 0, 0, 1)};
    run_program(2, 30);
    check("t3_n", log_d.size(), 2);
    if (log_d.size() == 2) begin
      check("t3_d0", log_d[0], 32'h1109FFFF);
      check("t3_a1", log_a[1], 32'h4);
    end

    prog = '{mk(0, 1, 2, 3, 0, 0, 0), mk(15, 0, 0, 0, 0, 0, 0), mk(7, 4, 5, 0, 8, 0, 1)};
    run_program(0, 30);
    check("t4_n", log_d.size(), 2);
    check("t4_err", err, 1);
    if (log_a.size() == 2) check("t4_a1", log_a[1], 32'h4);

    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(mk(6, i, i + 1, 0, i, 0, i == 4));
    run_program(0, 20);
    check("t5_n", log_d.size(), 4);
    check("t5_err", err, 1);
    check("t5_ready", bus.req_ready, 0);

    prog = '{mk(13, 8, 2, 0, 8, 0, 1)};
    run_program(0, 20);
`ifdef FP_LDST_EN
    check("t6_n", log_d.size(), 1);
    if (log_d.size() == 1) check("t6_data", log_d[0], 32'hC5020008);
    check("t6_err", err, 0);
`else
    check("t6_n", log_d.size(), 0);
    check("t6_err", err, 1);
`endif

    for (int p = 0; p < 60; p++) begin
      int unsigned len;
      len = $urandom_range(1, 6);
      prog = {};
      for (int i = 0; i < len; i++) begin
        r = mk($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom, $urandom, i == len - 1);
        prog.push_back(r);
      end
      run_program(1, 40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the main control decoder: packs mnemonic-level requests (op select, register numbers, immediate, jump target) into 32-bit MIPS instruction words.
- Streams the words into the instruction-memory write port at auto-incrementing word addresses.
- Used by the self-test/boot path to build programs that the single-cycle core then fetches and decodes.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written after start.
- DEPTH, 256, maximum number of instruction words per program; overflow beyond this is flagged.
- CNT_W, 9, width of the word counter; must hold DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new program at BASE_ADDR.
- req_valid  input  1  request present.
- req_ready  output  1  encoder can accept the request this cycle.
- req_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 J, 12 JAL, 13 LWC1, 14 SWC1, 15 illegal.
- req_rs  input  5  rs field.
- req_rt  input  5  rt field.
- req_rd  input  5  rd field (R-type only).
- req_imm  input  16  immediate or branch offset.
- req_target  input  26  jump target (J, JAL).
- req_last  input  1  marks the final request of the program.
- wr_en  output  1  instruction-memory write strobe.
- wr_ready  input  1  memory accepts the write this cycle.
- wr_addr  output  32  byte address of the write.
- wr_data  output  32  encoded instruction word.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  one-cycle pulse when the program is complete.
- err  output  1  sticky error: illegal op or overflow; cleared by start.
- word_cnt  output  CNT_W  number of words written since start.

Behaviour:
- Reset: state IDLE; req_ready, wr_en, busy, done and err are 0; wr_addr = BASE_ADDR; wr_data and word_cnt are 0.
- States: IDLE -> RUN on start. RUN -> DRAIN when a request with req_last is accepted. DRAIN -> DONE when the pending write completes. DONE -> IDLE next cycle, with done = 1 for that single cycle.
- start in RUN or DRAIN restarts the program: the pending write is dropped, the address returns to BASE_ADDR, word_cnt and err clear, and the state goes to RUN.
- Output register: one entry. req_ready = (state == RUN) & (~wr_en | wr_ready) & (word_cnt + pending < DEPTH).
- Latency: a request accepted in cycle N drives wr_en = 1 with the encoded wr_data in cycle N+1.
- A write completes on wr_en & wr_ready. On completion, wr_addr += 4 and word_cnt += 1.
- wr_en, wr_addr and wr_data are held stable while wr_ready = 0. Back-to-back throughput is 1 word/cycle.
- Encoding:
  - R-type ops: opcode 0, shamt 0; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - JR: opcode 0, rs only, rt/rd/shamt zero, funct 0x08.
  - I-type ops use {op, rs, rt, imm}: ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
  - J-type: J 0x02, JAL 0x03, encoded as {op, target}.
- Illegal op (15, or 13/14 with the feature off): the request is accepted but no write is issued; err is set. If req_last is set on it, go to DRAIN (or straight to DONE if nothing is pending).
- Overflow: when word_cnt plus pending equals DEPTH and req_valid = 1 without completion, set err; an accepted req_last still finishes normally.
- wr_addr wraps modulo 2^32. No other wrap occurs because DEPTH bounds the counter.

Optional Feature:
- Macro FP_LDST_EN.
- Defined: op 13 encodes LWC1 (opcode 0x31) and op 14 encodes SWC1 (opcode 0x39), both {op, rs, ft=req_rt, imm}.
- Undefined: ops 13 and 14 are illegal (err set, no write) and the FP encode logic is absent.

Test Plan:
- start; ADDI rs=0 rt=8 imm=5, last -> one write at 0x0 with data 0x20080005; done pulses one cycle after the write completes; word_cnt = 1.
- ADD rs=8 rt=9 rd=10; LW rs=29 rt=9 imm=4; JR rs=31; J target=0x100000 (last), wr_ready held 1 -> four consecutive writes at 0x0/0x4/0x8/0xC with data 0x01095020, 0x8FA90004, 0x03E00008, 0x08100000.
- BEQ rs=8 rt=9 imm=0xFFFF with wr_ready low for 3 cycles -> wr_data 0x1109FFFF and wr_addr held stable; req_ready = 0 until the write completes.
- Op 15 mid-program -> err = 1, no write issued, following addresses contiguous; a later start clears err and word_cnt.
- DEPTH=4 with 5 requests -> exactly 4 writes, err = 1, req_ready stays 0 after the fourth.
- With FP_LDST_EN: LWC1 rs=8 rt=2 imm=8 -> 0xC5020008. Without it: the same request sets err and issues no write.
